// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the reverse double-dabble BCD-to-binary converter.
package bcd_conv_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int         BCD_DIGITS = 4;
   localparam int         BCD_SHIFTS = 14;
   localparam bcd_digit_t BCD_CORR   = 4'd3;
   localparam bcd_digit_t BCD_THRESH = 4'd8;

endpackage

// File: rtl/bcd_digit_correct.sv
// Per-digit correction after a right shift: digits >= 8 lose 3 (pure combinational).
module bcd_digit_correct
   import bcd_conv_pkg::*;
(
   input  bcd_digit_t digit_i,
   output bcd_digit_t digit_o
);

   // A value >= 8 means a bit worth 10 arrived from the digit above; halved it is worth 5, not 8.
   assign digit_o = (digit_i >= BCD_THRESH) ? digit_i - BCD_CORR : digit_i;

endmodule

// File: rtl/bcd_to_binary_big.sv
// Sequential 4-digit BCD to 16-bit binary converter, SHIFTS+2 cycle latency, start ignored while busy.
// Optional BCD_INVALID_CHECK_EN adds bcd_err and short-circuits conversion of non-decimal digits.
module bcd_to_binary_big
   import bcd_conv_pkg::*;
#(
   parameter int DIGITS = BCD_DIGITS,
   parameter int OUT_W  = 16,
   parameter int SHIFTS = BCD_SHIFTS
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       thousands,
   input  logic [3:0]       hundreds,
   input  logic [3:0]       tens,
   input  logic [3:0]       ones,
   output logic             busy,
   output logic             done,
`ifdef BCD_INVALID_CHECK_EN
   output logic             bcd_err,
`endif
   output logic [OUT_W-1:0] sixteen_bit_value
);

   localparam int BW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(SHIFTS + 1);

   state_t              state_q, state_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [SHIFTS-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0]    val_q, val_d;
   logic                done_q, done_d;

   logic [BW-1:0]        bcd_in;
   logic [BW+SHIFTS-1:0] shifted;
   logic [BW-1:0]        bcd_corr;

   assign bcd_in  = BW'({thousands, hundreds, tens, ones});
   assign shifted = {bcd_q, bin_q} >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_digit_correct u_corr (
         .digit_i (shifted[SHIFTS + 4*g +: 4]),
         .digit_o (bcd_corr[4*g +: 4])
      );
   end

`ifdef BCD_INVALID_CHECK_EN
   logic in_invalid;
   logic err_q, err_d;
   logic bcd_err_q, bcd_err_d;

   assign in_invalid = (thousands > 4'd9) || (hundreds > 4'd9) ||
                       (tens > 4'd9) || (ones > 4'd9);
   assign bcd_err    = bcd_err_q;
`endif

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      done_d  = 1'b0;
`ifdef BCD_INVALID_CHECK_EN
      err_d     = err_q;
      bcd_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               bcd_d   = bcd_in;
               bin_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef BCD_INVALID_CHECK_EN
               err_d = in_invalid;
               if (in_invalid) state_d = DONE;
`endif
            end
         end
         SHIFT: begin
            bcd_d = bcd_corr;
            bin_d = shifted[SHIFTS-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SHIFTS - 1)) state_d = DONE;
         end
         DONE: begin
            val_d   = OUT_W'(bin_q);
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef BCD_INVALID_CHECK_EN
            bcd_err_d = err_q;
            if (err_q) val_d = '0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         val_q   <= '0;
         done_q  <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
         err_q     <= 1'b0;
         bcd_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         done_q  <= done_d;
`ifdef BCD_INVALID_CHECK_EN
         err_q     <= err_d;
         bcd_err_q <= bcd_err_d;
`endif
      end
   end

   assign busy              = (state_q != IDLE);
   assign done              = done_q;
   assign sixteen_bit_value = val_q;

endmodule
